fetch_prefetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the next-generation core. Replaces direct
//  PC->instROM coupling with a registered fetch PC, a 1-cycle synchronous ROM interface
//  and a DEPTH-entry prefetch FIFO with valid/ready handoff to decode. Accepts branch

---
 rtl/fetch_prefetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: registered fetch PC driving a 1-cycle synchronous
// ROM, a DEPTH-entry prefetch FIFO with valid/ready handoff to decode, branch
// redirect with full flush, sticky halt, and a saturating retired-instruction count.
module fetch_prefetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INST_W   = 9,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] START_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              start_n,
    output logic [PC_W-1:0]   rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    input  logic              branch_i,
    input  logic [PC_W-1:0]   target_i,
    input  logic              halt_i,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retired_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PC_W-1:0]   r_fetchPc;
    logic [PC_W-1:0]   r_pcQ;
    logic              r_inflight;
    logic [PC_W-1:0]   r_memPc   [DEPTH];
    logic [INST_W-1:0] r_memInst [DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [OCC_W-1:0]  r_count;
    logic              r_haltLatch;
    logic [CNT_W-1:0]  r_retired;

    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic [OCC_W-1:0]  w_occupancy;

    // Handshake and credit decisions; a same-cycle pop deliberately grants no credit
    // so the issue path never depends on the decode ready input.
    always_comb begin
        w_empty     = (r_count == '0);
        w_pop       = !w_empty && inst_ready_i;
        w_push      = r_inflight && !branch_i;
        w_occupancy = r_count + OCC_W'(r_inflight);
        w_issue     = !r_haltLatch && !halt_i && !branch_i &&
                      (w_occupancy < OCC_W'(DEPTH));
    end

    // Fetch PC, in-flight tracking, FIFO pointers/count, halt latch and retire counter.
    always_ff @(posedge CLK) begin
        if (!start_n) begin
            r_fetchPc   <= START_PC;
            r_pcQ       <= '0;
            r_inflight  <= 1'b0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_haltLatch <= 1'b0;
            r_retired   <= '0;
        end else begin
            if (halt_i) begin
                r_haltLatch <= 1'b1;
            end

            if (w_pop && (r_retired != '1)) begin
                r_retired <= r_retired + CNT_W'(1);
            end

            if (branch_i) begin
                r_fetchPc  <= target_i;
                r_inflight <= 1'b0;
                r_wrPtr    <= '0;
                r_rdPtr    <= '0;
                r_count    <= '0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_pcQ     <= r_fetchPc;
                    r_fetchPc <= r_fetchPc + PC_W'(1);
                end
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + OCC_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - OCC_W'(1);
                end
            end
        end
    end

    // FIFO storage; contents need no reset because the outputs are gated by the count.
    always_ff @(posedge CLK) begin
        if (start_n && w_push) begin
            r_memPc[r_wrPtr]   <= r_pcQ;
            r_memInst[r_wrPtr] <= rom_data_i;
        end
    end

    // Outputs are pure functions of registered state.
    always_comb begin
        rom_addr_o   = r_fetchPc;
        inst_valid_o = !w_empty;
        inst_o       = w_empty ? '0 : r_memInst[r_rdPtr];
        inst_pc_o    = w_empty ? '0 : r_memPc[r_rdPtr];
        halted_o     = r_haltLatch && w_empty && !r_inflight;
        retired_o    = r_retired;
    end

    // The credit rule guarantees a returning fetch always finds a free slot.
    assert property (@(posedge CLK) disable iff (!start_n)
                     !(w_push && (r_count == OCC_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a per-cycle vector table for fill,
// backpressure, branch and halt, plus hand-written reset and saturation sequences.
module tb_fetch_prefetch_unit;

    typedef struct {
        logic        ready;
        logic        branch;
        logic [7:0]  target;
        logic        halt;
        logic [7:0]  expAddr;
        logic        expValid;
        logic [7:0]  expPc;
        logic [8:0]  expInst;
        logic [15:0] expRetired;
        logic        expHalted;
    } vec_t;

    logic CLK = 1'b0;
    logic startN, ready, branch, halt;
    logic [7:0] target;

    logic [7:0]  addrA, pcA;
    logic [8:0]  instA, romA;
    logic        validA, haltedA;
    logic [15:0] retiredA;

    logic [7:0]  addrB, pcB;
    logic [8:0]  instB, romB;
    logic        validB, haltedB;
    logic [15:0] retiredB;

    logic [7:0]  addrC, pcC;
    logic [8:0]  instC, romC;
    logic        validC, haltedC;
    logic [3:0]  retiredC;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 CLK = ~CLK;

    // ROM models: contents are address | 0x100, one-cycle registered read
    always @(posedge CLK) begin
        romA <= {1'b1, addrA};
        romB <= {1'b1, addrB};
        romC <= {1'b1, addrC};
    end

    fetch_prefetch_unit dutA (
        .CLK(CLK), .start_n(startN), .rom_addr_o(addrA), .rom_data_i(romA),
        .inst_o(instA), .inst_pc_o(pcA), .inst_valid_o(validA), .inst_ready_i(ready),
        .branch_i(branch), .target_i(target), .halt_i(halt), .halted_o(haltedA),
        .retired_o(retiredA)
    );

    fetch_prefetch_unit #(.START_PC(8'hFE)) dutB (
        .CLK(CLK), .start_n(startN), .rom_addr_o(addrB), .rom_data_i(romB),
        .inst_o(instB), .inst_pc_o(pcB), .inst_valid_o(validB), .inst_ready_i(ready),
        .branch_i(branch), .target_i(target), .halt_i(halt), .halted_o(haltedB),
        .retired_o(retiredB)
    );

    fetch_prefetch_unit #(.CNT_W(4)) dutC (
        .CLK(CLK), .start_n(startN), .rom_addr_o(addrC), .rom_data_i(romC),
        .inst_o(instC), .inst_pc_o(pcC), .inst_valid_o(validC), .inst_ready_i(ready),
        .branch_i(branch), .target_i(target), .halt_i(halt), .halted_o(haltedC),
        .retired_o(retiredC)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic b, input logic [7:0] t, input logic h,
                          input logic [7:0] a, input logic v, input logic [7:0] p,
                          input logic [15:0] ret, input logic hl);
        vec_t x;
        x.ready      = r;
        x.branch     = b;
        x.target     = t;
        x.halt       = h;
        x.expAddr    = a;
        x.expValid   = v;
        x.expPc      = p;
        x.expInst    = v ? {1'b1, p} : 9'h000;
        x.expRetired = ret;
        x.expHalted  = hl;
        vecs.push_back(x);
    endtask

    task automatic applyStimulus(input vec_t v);
        startN = 1'b1;
        ready  = v.ready;
        branch = v.branch;
        target = v.target;
        halt   = v.halt;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("c%0d addr", idx),    32'(addrA),    32'(v.expAddr));
        checkVal($sformatf("c%0d valid", idx),   32'(validA),   32'(v.expValid));
        checkVal($sformatf("c%0d pc", idx),      32'(pcA),      32'(v.expPc));
        checkVal($sformatf("c%0d inst", idx),    32'(instA),    32'(v.expInst));
        checkVal($sformatf("c%0d retired", idx), 32'(retiredA), 32'(v.expRetired));
        checkVal($sformatf("c%0d halted", idx),  32'(haltedA),  32'(v.expHalted));
    endtask

    task automatic applyReset(input int n);
        startN = 1'b0;
        ready  = 1'b0;
        branch = 1'b0;
        target = 8'h00;
        halt   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic buildVectors();
        //     rdy   br    tgt    hlt   addr   vld   pc     ret    halted
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 16'd0,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 8'h00, 16'd0,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h00, 16'd0,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 8'h01, 16'd1,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 8'h02, 16'd2,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 8'h03, 16'd3,  1'b0);
        addVec(1'b0, 1'b0, 8'h00, 1'b0, 8'h06, 1'b1, 8'h04, 16'd4,  1'b0);
        addVec(1'b0, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 8'h04, 16'd4,  1'b0);
        addVec(1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 1'b1, 8'h04, 16'd4,  1'b0);
        addVec(1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 1'b1, 8'h04, 16'd4,  1'b0);
        addVec(1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 1'b1, 8'h04, 16'd4,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h08, 1'b1, 8'h04, 16'd4,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h08, 1'b1, 8'h05, 16'd5,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h09, 1'b1, 8'h06, 16'd6,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h0A, 1'b1, 8'h07, 16'd7,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h0B, 1'b1, 8'h08, 16'd8,  1'b0);
        addVec(1'b1, 1'b1, 8'h40, 1'b0, 8'h0C, 1'b1, 8'h09, 16'd9,  1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0, 8'h00, 16'd10, 1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 8'h00, 16'd10, 1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h42, 1'b1, 8'h40, 16'd10, 1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h43, 1'b1, 8'h41, 16'd11, 1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 8'h42, 16'd12, 1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b1, 8'h45, 1'b1, 8'h43, 16'd13, 1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h45, 1'b1, 8'h44, 16'd14, 1'b0);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h45, 1'b0, 8'h00, 16'd15, 1'b1);
        addVec(1'b1, 1'b1, 8'h80, 1'b0, 8'h45, 1'b0, 8'h00, 16'd15, 1'b1);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h80, 1'b0, 8'h00, 16'd15, 1'b1);
        addVec(1'b1, 1'b0, 8'h00, 1'b0, 8'h80, 1'b0, 8'h00, 16'd15, 1'b1);
    endtask

    initial begin
        int expRet;
        startN = 1'b0;
        ready  = 1'b0;
        branch = 1'b0;
        target = 8'h00;
        halt   = 1'b0;
        buildVectors();

        // Reset state
        applyReset(2);
        checkVal("reset addr",    32'(addrA),    32'h00);
        checkVal("reset valid",   32'(validA),   32'h0);
        checkVal("reset pc",      32'(pcA),      32'h00);
        checkVal("reset inst",    32'(instA),    32'h000);
        checkVal("reset retired", 32'(retiredA), 32'h0);
        checkVal("reset halted",  32'(haltedA),  32'h0);
        checkVal("reset addrB",   32'(addrB),    32'hFE);

        // Fill, backpressure, branch redirect, halt and branch-while-halted
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
            tick();
        end

        // Reset clears a latched halt
        applyReset(2);
        checkVal("halt cleared", 32'(haltedA), 32'h0);

        // Fill three entries with one fetch in flight, then reset mid-stream
        startN = 1'b1;
        repeat (4) tick();
        checkVal("prefill valid", 32'(validA), 32'h1);
        checkVal("prefill pc",    32'(pcA),    32'h00);
        checkVal("prefill addr",  32'(addrA),  32'h04);
        checkVal("prefill pcB",   32'(pcB),    32'hFE);
        startN = 1'b0;
        tick();
        checkVal("midreset valid",   32'(validA),   32'h0);
        checkVal("midreset retired", 32'(retiredA), 32'h0);
        checkVal("midreset addr",    32'(addrA),    32'h00);
        checkVal("midreset pc",      32'(pcA),      32'h00);

        // Refetch from START_PC at full rate; counter saturation on the narrow instance
        startN = 1'b1;
        ready  = 1'b1;
        for (int k = 0; k < 22; k++) begin
            expRet = (k < 2) ? 0 : k - 2;
            checkVal($sformatf("run%0d addr", k),    32'(addrA),    32'(k));
            checkVal($sformatf("run%0d valid", k),   32'(validA),   (k >= 2) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                checkVal($sformatf("run%0d pc", k),   32'(pcA),   32'(k - 2));
                checkVal($sformatf("run%0d inst", k), 32'(instA), 32'(9'h100 + 9'(k - 2)));
            end
            checkVal($sformatf("run%0d retired", k),  32'(retiredA), 32'(expRet));
            checkVal($sformatf("run%0d retiredC", k), 32'(retiredC), 32'((expRet > 15) ? 15 : expRet));
            if (k >= 2 && k <= 5) begin
                checkVal($sformatf("run%0d pcB", k),   32'(pcB),   32'(8'(8'hFE + 8'(k - 2))));
                checkVal($sformatf("run%0d instB", k), 32'(instB), 32'({1'b1, 8'(8'hFE + 8'(k - 2))}));
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
